// File: rtl/apb_request_master_if.sv
// apb_request_master_if: request/response handshake and APB4 completer bus
// bundled for apb_request_master. The master modport is the bridge's view;
// the slave modport is the view of the surrounding transactor and APB target.
interface apb_request_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // request channel from the AXI4-Lite transactor
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_prot;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_wstrb;

    // completion channel back to the transactor
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;

    // APB4 requester side
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [2:0]            pprot;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_prot, req_wdata, req_wstrb,
        output req_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_prot, req_wdata, req_wstrb,
        input  req_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_request_master.sv
// apb_request_master: turns single request/response transactions into APB4
// transfers (IDLE -> SETUP -> ACCESS -> RESP), one transfer in flight.
// All outputs are registered. Optional macro APB_TIMEOUT_EN adds an ACCESS
// wait-state limit of TIMEOUT_CYCLES that completes the transfer with SLVERR.
module apb_request_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_request_master_if.master bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TCNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_WIDTH-1:0] tcnt_q, tcnt_d;
`endif

    logic [1:0]            state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;

    // State and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pprot_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
`ifdef APB_TIMEOUT_EN
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pprot_q     <= pprot_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
`ifdef APB_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    // Next state and next output values; everything holds unless a transition changes it.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pprot_d     = pprot_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
`ifdef APB_TIMEOUT_EN
        tcnt_d      = tcnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d     = SETUP;
                    req_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = bus.req_write;
                    paddr_d     = bus.req_addr;
                    pprot_d     = bus.req_prot;
                    // reads present zero write data and no byte lanes
                    pwdata_d    = bus.req_write ? bus.req_wdata : '0;
                    pstrb_d     = bus.req_write ? bus.req_wstrb : '0;
`ifdef APB_TIMEOUT_EN
                    tcnt_d      = '0;
`endif
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end

            ACCESS: begin
                if (bus.pready) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                    rsp_resp_d  = bus.pslverr ? RESP_SLVERR : RESP_OKAY;
                end
`ifdef APB_TIMEOUT_EN
                else if (tcnt_q == TCNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    // completer never answered: give up and report SLVERR
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = RESP_SLVERR;
                end else begin
                    tcnt_d = tcnt_q + TCNT_WIDTH'(1);
                end
`endif
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drive the bus from the output registers.
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_resp  = rsp_resp_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pprot     = pprot_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;

endmodule

// File: tb/tb_apb_request_master.sv
// tb_apb_request_master: directed vector table plus hand-written sequences
// for reset, back-to-back, abort and (with APB_TIMEOUT_EN) timeout.
module tb_apb_request_master;

    logic clk;
    logic rst;

    apb_request_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_request_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        int          rsp_hold;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // step into the next cycle, landing 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        chk({t, " idle req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = v.write;
        bus.req_addr  = v.addr;
        bus.req_prot  = v.prot;
        bus.req_wdata = v.wdata;
        bus.req_wstrb = v.wstrb;
        step();
        // scramble the request so only registered copies can be on the bus
        bus.req_valid = 1'b0;
        bus.req_addr  = ~v.addr;
        bus.req_wdata = ~v.wdata;
        bus.req_wstrb = ~v.wstrb;
        bus.req_prot  = ~v.prot;
        bus.req_write = ~v.write;
        // SETUP: completer response here must be ignored
        chk({t, " setup psel"}, 32'(bus.psel), 32'd1);
        chk({t, " setup penable"}, 32'(bus.penable), 32'd0);
        chk({t, " setup paddr"}, bus.paddr, v.addr);
        chk({t, " setup pwrite"}, 32'(bus.pwrite), 32'(v.write));
        chk({t, " setup pprot"}, 32'(bus.pprot), 32'(v.prot));
        chk({t, " setup pwdata"}, bus.pwdata, v.exp_pwdata);
        chk({t, " setup pstrb"}, 32'(bus.pstrb), 32'(v.exp_pstrb));
        chk({t, " setup req_ready"}, 32'(bus.req_ready), 32'd0);
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        bus.prdata  = 32'hFFFF_0000;
        step();
        for (int k = 0; k <= v.waits; k++) begin
            bus.pready  = (k == v.waits);
            bus.pslverr = (k == v.waits) ? v.slverr : 1'b1;
            bus.prdata  = (k == v.waits) ? v.prdata : 32'h0BAD_0BAD;
            chk({t, $sformatf(" access%0d psel", k)}, 32'(bus.psel), 32'd1);
            chk({t, $sformatf(" access%0d penable", k)}, 32'(bus.penable), 32'd1);
            chk({t, $sformatf(" access%0d paddr", k)}, bus.paddr, v.addr);
            chk({t, $sformatf(" access%0d pwdata", k)}, bus.pwdata, v.exp_pwdata);
            chk({t, $sformatf(" access%0d pstrb", k)}, 32'(bus.pstrb), 32'(v.exp_pstrb));
            chk({t, $sformatf(" access%0d rsp_valid", k)}, 32'(bus.rsp_valid), 32'd0);
            step();
        end
        // RESP: APB inputs toggled to junk must not disturb the response
        bus.pready  = 1'b1;
        bus.pslverr = ~v.slverr;
        bus.prdata  = 32'h7777_7777;
        for (int h = 0; h <= v.rsp_hold; h++) begin
            bus.rsp_ready = (h == v.rsp_hold);
            chk({t, $sformatf(" resp%0d rsp_valid", h)}, 32'(bus.rsp_valid), 32'd1);
            chk({t, $sformatf(" resp%0d rsp_write", h)}, 32'(bus.rsp_write), 32'(v.write));
            chk({t, $sformatf(" resp%0d rsp_rdata", h)}, bus.rsp_rdata, v.exp_rdata);
            chk({t, $sformatf(" resp%0d rsp_resp", h)}, 32'(bus.rsp_resp), 32'(v.exp_resp));
            chk({t, $sformatf(" resp%0d psel", h)}, 32'(bus.psel), 32'd0);
            chk({t, $sformatf(" resp%0d penable", h)}, 32'(bus.penable), 32'd0);
            chk({t, $sformatf(" resp%0d req_ready", h)}, 32'(bus.req_ready), 32'd0);
            step();
        end
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        chk({t, " done rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({t, " done req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    // watchdog so a stuck bench still ends
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        vec_t lw;
        int first_setup;
        int second_setup;
        int acc_cnt;

        n_vec = 0;
        n_err = 0;

        //         wr    addr           prot    wdata          strb   ws sl  prdata         hold pwdata         pstrb  rdata          resp
        vecs[0] = '{1'b1, 32'h0000_0010, 3'b000, 32'hDEAD_BEEF, 4'hF,  0, 1'b0, 32'hAAAA_5555, 0, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        vecs[1] = '{1'b0, 32'h0000_0044, 3'b010, 32'hCAFE_F00D, 4'hF,  3, 1'b0, 32'h1234_5678, 0, 32'h0,         4'h0, 32'h1234_5678, 2'b00};
        vecs[2] = '{1'b1, 32'h0000_0020, 3'b001, 32'h0102_0304, 4'h5,  1, 1'b1, 32'h5A5A_5A5A, 5, 32'h0102_0304, 4'h5, 32'h0,         2'b10};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 3'b100, 32'h1111_1111, 4'h3,  0, 1'b1, 32'hBADC_0DE5, 2, 32'h0,         4'h0, 32'hBADC_0DE5, 2'b10};
        vecs[4] = '{1'b1, 32'h8000_0000, 3'b111, 32'hFFFF_FFFF, 4'h0,  2, 1'b0, 32'h0,         1, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00};
        vecs[5] = '{1'b0, 32'h0000_0300, 3'b011, 32'h0,         4'h0, 12, 1'b0, 32'h8765_4321, 0, 32'h0,         4'h0, 32'h8765_4321, 2'b00};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_prot  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = '0;
        step();
        step();

        // reset values while reset is held
        chk("rst req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst rsp_resp", 32'(bus.rsp_resp), 32'd0);
        chk("rst rsp_write", 32'(bus.rsp_write), 32'd0);
        chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst psel", 32'(bus.psel), 32'd0);
        chk("rst penable", 32'(bus.penable), 32'd0);
        chk("rst pwrite", 32'(bus.pwrite), 32'd0);
        chk("rst paddr", bus.paddr, 32'd0);
        chk("rst pprot", 32'(bus.pprot), 32'd0);
        chk("rst pwdata", bus.pwdata, 32'd0);
        chk("rst pstrb", 32'(bus.pstrb), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
            step();
        end

        // back-to-back reads with req_valid and rsp_ready held high
        first_setup   = -1;
        second_setup  = -1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0100;
        bus.rsp_ready = 1'b1;
        bus.pready    = 1'b1;
        bus.pslverr   = 1'b0;
        bus.prdata    = 32'h0000_0055;
        for (int c = 0; c < 30; c++) begin
            if (bus.psel && !bus.penable) begin
                if (first_setup < 0) first_setup = c;
                else if (second_setup < 0) second_setup = c;
            end
            if (bus.rsp_valid) chk("b2b rsp_rdata", bus.rsp_rdata, 32'h0000_0055);
            if (second_setup >= 0) begin
                bus.req_valid = 1'b0;
                break;
            end
            step();
        end
        chk("b2b first setup cycle", 32'(first_setup), 32'd1);
        chk("b2b setup spacing", 32'(second_setup - first_setup), 32'd4);
        bus.req_valid = 1'b0;
        for (int c = 0; c < 6; c++) step();
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        chk("b2b idle req_ready", 32'(bus.req_ready), 32'd1);

        // reset pulse in the middle of ACCESS aborts without a response
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0040;
        bus.req_wdata = 32'h0BEE_F00D;
        bus.req_wstrb = 4'hF;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        chk("abort pre penable", 32'(bus.penable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort psel", 32'(bus.psel), 32'd0);
        chk("abort penable", 32'(bus.penable), 32'd0);
        chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.pready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("abort after%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd0);
            chk($sformatf("abort after%0d psel", c), 32'(bus.psel), 32'd0);
        end
        bus.pready = 1'b0;
        chk("abort idle req_ready", 32'(bus.req_ready), 32'd1);

`ifdef APB_TIMEOUT_EN
        // completer never answers: SLVERR after 16 ACCESS cycles
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0200;
        bus.prdata    = 32'hDEAD_DEAD;
        step();
        bus.req_valid = 1'b0;
        step();
        acc_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!(bus.psel && bus.penable)) break;
            acc_cnt++;
            step();
        end
        chk("timeout access cycles", 32'(acc_cnt), 32'd16);
        chk("timeout psel", 32'(bus.psel), 32'd0);
        chk("timeout rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("timeout rsp_resp", 32'(bus.rsp_resp), 32'd2);
        chk("timeout rsp_rdata", bus.rsp_rdata, 32'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("timeout idle req_ready", 32'(bus.req_ready), 32'd1);
`else
        // without the timeout, a long wait still completes normally
        acc_cnt = 0;
        lw = '{1'b0, 32'h0000_0400, 3'b000, 32'h0, 4'h0, 25, 1'b0, 32'h0F0F_F0F0, 0, 32'h0, 4'h0, 32'h0F0F_F0F0, 2'b00};
        run_vec(lw, 6);
        chk("longwait acc_cnt unused", 32'(acc_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
